// File: rtl/tristate_bus_arbiter.sv
// Two-requester owner of a shared 2-bit tristate bus: grants and drives from the sampling edge,
// holds a grant up to HOLD_MAX cycles, idles the bus TURN_CYC cycles between owners, samples on rd_req.
module tristate_bus_arbiter #(
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] wdata0,
  input  logic [1:0] wdata1,
  input  logic       rd_req,
  inout  wire  [1:0] io,
  output logic [1:0] gnt,
  output logic [1:0] rdata,
  output logic       rvalid,
  output logic       busy
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
  localparam logic [TW-1:0] TURN_LIM = TW'(TURN_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN,
    S_READ
  } state_t;

  state_t        state_q, state_d;
  state_t        arb_state;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [1:0]    rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          arb_owner;
  logic          drive;
  logic [1:0]    drv_dat;

  // Drive requests win over reads; a tie goes to the round-robin pointer.
  always_comb begin
    arb_owner = (req == 2'b11) ? rr_q : req[1];
    if (|req) begin
      arb_state = S_DRIVE;
    end else if (rd_req) begin
      arb_state = S_READ;
    end else begin
      arb_state = S_IDLE;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = arb_state;
        if (|req) begin
          owner_d = arb_owner;
          hold_d  = HW'(1);
        end
      end
      S_DRIVE: begin
        if (req[owner_q] && (hold_q < HOLD_LIM)) begin
          hold_d = hold_q + HW'(1);
        end else begin
          state_d = S_TURN;
          turn_d  = TW'(1);
          hold_d  = '0;
          rr_d    = ~owner_q;
        end
      end
      S_TURN: begin
        // The last turnaround edge arbitrates as IDLE would, so the gap is exactly TURN_CYC.
        if (turn_q >= TURN_LIM) begin
          state_d = arb_state;
          if (|req) begin
            owner_d = arb_owner;
            hold_d  = HW'(1);
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      S_READ: begin
        rdata_d  = io;
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      hold_q   <= '0;
      turn_q   <= '0;
      rdata_q  <= 2'b00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Bus enable comes straight from the state flop, so reset releases io without a clock.
  assign drive   = (state_q == S_DRIVE);
  assign drv_dat = owner_q ? wdata1 : wdata0;
  assign io      = drive ? drv_dat : 2'bzz;
  assign gnt     = drive ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy    = (state_q != S_IDLE);
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: vector table, hand sequences for reset/turnaround, random run vs model.
// The buses carry pull-ups, so a released (ZZ) bus reads 2'b11 here.
module tb_tristate_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] req, wdata0, wdata1;
  logic       rd_req;
  logic       ext_en;
  logic [1:0] ext_dat;
  wire  [1:0] io1, io3;
  logic [1:0] gnt1, rdata1, gnt3, rdata3;
  logic       rvalid1, busy1, rvalid3, busy3;

  assign io1 = ext_en ? ext_dat : 2'bzz;
  pullup pu10 (io1[0]);
  pullup pu11 (io1[1]);
  pullup pu30 (io3[0]);
  pullup pu31 (io3[1]);

  tristate_bus_arbiter #(.TURN_CYC(1), .HOLD_MAX(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata0(wdata0), .wdata1(wdata1),
    .rd_req(rd_req), .io(io1), .gnt(gnt1), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
  );

  tristate_bus_arbiter #(.TURN_CYC(3), .HOLD_MAX(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata0(wdata0), .wdata1(wdata1),
    .rd_req(rd_req), .io(io3), .gnt(gnt3), .rdata(rdata3), .rvalid(rvalid3), .busy(busy3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] req, wd0, wd1;
    logic       rd, xen;
    logic [1:0] xdat;
    logic [1:0] gnt, io, rdata;
    logic       rvalid, busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model, parameters of u_dut1. Phases: 0 idle, 1 drive, 2 turnaround, 3 read.
  localparam int TC = 1;
  localparam int HM = 4;
  int         m_phase, m_owner, m_rr, m_used, m_gap;
  logic [1:0] m_rdata;
  logic       m_rvalid;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_used = 0; m_gap = 0;
    m_rdata = 2'b00; m_rvalid = 1'b0;
  endtask

  task automatic model_arb(input logic [1:0] r, input logic rd);
    if (r != 2'b00) begin
      m_phase = 1;
      m_owner = (r == 2'b11) ? m_rr : ((r == 2'b10) ? 1 : 0);
      m_used  = 1;
    end else if (rd) begin
      m_phase = 3;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic model_step(input logic [1:0] r, input logic rd, input logic [1:0] bus);
    m_rvalid = (m_phase == 3);
    if (m_phase == 3) m_rdata = bus;
    case (m_phase)
      0: model_arb(r, rd);
      1: begin
        if (r[m_owner] && m_used < HM) begin
          m_used++;
        end else begin
          m_phase = 2;
          m_gap   = TC;
          m_rr    = 1 - m_owner;
        end
      end
      2: begin
        m_gap--;
        if (m_gap == 0) model_arb(r, rd);
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [1:0] wsel(input int owner);
    return (owner == 1) ? wdata1 : wdata0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [1:0] exp_gnt, exp_io, bus;

    rst_n = 1'b0; req = 2'b11; wdata0 = 2'b10; wdata1 = 2'b01; rd_req = 1'b1;
    ext_en = 1'b0; ext_dat = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {gnt1, io1, rdata1, rvalid1, busy1}, {2'b00, 2'b11, 2'b00, 1'b0, 1'b0});
    req = 2'b00; rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single owner held two cycles, then dropped
    tbl.push_back('{2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1});
    tbl.push_back('{2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0});
    // drive request beats a simultaneous read; read follows the turnaround
    tbl.push_back('{2'b10, 2'b10, 2'b01, 1'b1, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b10, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b10, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b10, 2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b01, 1'b0, 1'b0});
    // plain read from idle
    tbl.push_back('{2'b00, 2'b10, 2'b01, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b10, 2'b01, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 1'b0, 1'b0});
    // continuous tie: 4 cycles each owner, one turnaround cycle between
    for (int i = 0; i < 14; i++) begin
      if (i % 5 == 4) begin
        exp_gnt = 2'b00; exp_io = 2'b11;
      end else if ((i / 5) % 2 == 0) begin
        exp_gnt = 2'b01; exp_io = 2'b01;
      end else begin
        exp_gnt = 2'b10; exp_io = 2'b10;
      end
      tbl.push_back('{2'b11, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, exp_gnt, exp_io, 2'b10, 1'b0, 1'b1});
    end
    tbl.push_back('{2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      v = tbl[i];
      req = v.req; wdata0 = v.wd0; wdata1 = v.wd1; rd_req = v.rd;
      ext_en = v.xen; ext_dat = v.xdat;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {gnt1, io1, rdata1, rvalid1, busy1},
            {v.gnt, v.io, v.rdata, v.rvalid, v.busy});
      @(negedge clk);
    end

    // async reset in the second drive cycle; pointer currently favours requester 1
    ext_en = 1'b0; req = 2'b10; wdata0 = 2'b10; wdata1 = 2'b01;
    @(posedge clk);
    #1;
    check("rst_drive_c1", {4'b0, gnt1, io1}, {4'b0, 2'b10, 2'b01});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_release", {3'b0, gnt1, io1, busy1}, {3'b0, 2'b00, 2'b11, 1'b0});
    req = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tie_to_r0", {4'b0, gnt1, io1}, {4'b0, 2'b01, 2'b10});
    req = 2'b00;
    repeat (4) @(posedge clk);

    // three-cycle turnaround on the TURN_CYC=3 / HOLD_MAX=2 instance
    @(negedge clk);
    rst_n = 1'b0;
    req = 2'b11; wdata0 = 2'b01; wdata1 = 2'b10; rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int p;
      p = i % 10;
      if (p < 2) begin
        exp_gnt = 2'b01; exp_io = 2'b01;
      end else if (p >= 5 && p < 7) begin
        exp_gnt = 2'b10; exp_io = 2'b10;
      end else begin
        exp_gnt = 2'b00; exp_io = 2'b11;
      end
      @(posedge clk);
      #1;
      check($sformatf("turn3_c%0d", i), {4'b0, gnt3, io3}, {4'b0, exp_gnt, exp_io});
    end

    // randomized run against the model
    @(negedge clk);
    rst_n = 1'b0; req = 2'b00; rd_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ext_en  = (m_phase == 3);
      ext_dat = 2'($urandom_range(0, 3));
      req     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) req = 2'b00;
      wdata0  = 2'($urandom_range(0, 3));
      wdata1  = 2'($urandom_range(0, 3));
      rd_req  = ($urandom_range(0, 2) == 0);
      bus = (m_phase == 1) ? wsel(m_owner) : (ext_en ? ext_dat : 2'b11);
      model_step(req, rd_req, bus);
      @(posedge clk);
      #1;
      exp_gnt = (m_phase == 1) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_io  = (m_phase == 1) ? wsel(m_owner) : (ext_en ? ext_dat : 2'b11);
      check($sformatf("rand%0d", i), {gnt1, io1, rdata1, rvalid1, busy1},
            {exp_gnt, exp_io, m_rdata, m_rvalid, (m_phase != 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
